// File: rtl/clock_divider_ctrl.sv
// Run controller for a toggling clock divider: start/stop, glitch-free rate change at wraps,
// optional fixed-length bursts (enabled by defining DIVCTRL_BURST_EN).
module clock_divider_ctrl #(
    parameter int          COUNT_WIDTH = 24,
    parameter int unsigned DEFAULT_MAX = 5999999,
    parameter int          BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [COUNT_WIDTH-1:0] cfg_max,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   out,
    output logic                   tick,
    output logic                   busy,
    output logic                   done
);

`ifdef DIVCTRL_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic [COUNT_WIDTH-1:0] active_max_reg, active_max_next;
    logic [COUNT_WIDTH-1:0] shadow_max_reg, shadow_max_next;
    logic                   pending_reg, pending_next;
    logic [BURST_WIDTH-1:0] toggle_cnt_reg, toggle_cnt_next;
    logic [BURST_WIDTH-1:0] burst_reg, burst_next;
    logic                   out_reg, out_next;
    logic                   tick_reg, tick_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;

    logic wrap;
    logic cfg_fire;
    logic copy;
    logic toggle;
    logic end_by_toggle;

    // Outputs are registered one cycle ahead: tick/out reflect the cycle in which
    // count equals active_max, so the toggle is computed from the next-state count.
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        toggle_cnt_next = toggle_cnt_reg;
        burst_next      = burst_reg;
        out_next        = out_reg;
        tick_next       = 1'b0;
        toggle          = 1'b0;
        end_by_toggle   = 1'b0;

        wrap     = (state_reg != IDLE) && (count_reg == active_max_reg);
        cfg_fire = cfg_valid && !pending_reg;
        copy     = pending_reg && ((state_reg == IDLE) || wrap);

        shadow_max_next = cfg_fire ? cfg_max : shadow_max_reg;
        active_max_next = copy ? shadow_max_reg : active_max_reg;
        pending_next    = cfg_fire || (pending_reg && !copy);

        case (state_reg)
            IDLE: begin
                count_next = '0;
                out_next   = 1'b0;
                if (start && !stop) begin
                    state_next      = RUN;
                    toggle_cnt_next = '0;
                    burst_next      = burst_len;
                end
            end
            RUN: begin
                count_next = wrap ? '0 : count_reg + COUNT_WIDTH'(1);
                if (stop) begin
                    state_next = out_reg ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                count_next = wrap ? '0 : count_reg + COUNT_WIDTH'(1);
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                out_next   = 1'b0;
            end
        endcase

        if (state_next != IDLE) begin
            toggle = (count_next == active_max_next);
            if (toggle) begin
                // A draining run ends on the toggle that brings out back low.
                if ((state_next == DRAIN) && out_next) begin
                    end_by_toggle = 1'b1;
                end
                out_next        = !out_next;
                tick_next       = 1'b1;
                toggle_cnt_next = toggle_cnt_next + BURST_WIDTH'(1);
                if (BURST_EN && (burst_next != '0) && (toggle_cnt_next == burst_next)) begin
                    end_by_toggle = 1'b1;
                end
            end
        end

        if (end_by_toggle) begin
            state_next = IDLE;
            count_next = '0;
        end

        busy_next = (state_next != IDLE);
        done_next = (state_next == IDLE) && ((state_reg != IDLE) || end_by_toggle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            active_max_reg <= COUNT_WIDTH'(DEFAULT_MAX);
            shadow_max_reg <= COUNT_WIDTH'(DEFAULT_MAX);
            pending_reg    <= 1'b0;
            toggle_cnt_reg <= '0;
            burst_reg      <= '0;
            out_reg        <= 1'b0;
            tick_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            active_max_reg <= active_max_next;
            shadow_max_reg <= shadow_max_next;
            pending_reg    <= pending_next;
            toggle_cnt_reg <= toggle_cnt_next;
            burst_reg      <= burst_next;
            out_reg        <= out_next;
            tick_reg       <= tick_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign cfg_ready = !pending_reg;
    assign out       = out_reg;
    assign tick      = tick_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl; burst expectations follow DIVCTRL_BURST_EN.
module tb_clock_divider_ctrl;
    localparam int          CW   = 24;
    localparam int          BW   = 8;
    localparam int unsigned DMAX = 6;

`ifdef DIVCTRL_BURST_EN
    localparam int EXP_BURST_TICKS = 4;
    localparam int EXP_BURST_DONE  = 1;
    localparam int EXP_BURST_OUT   = 0;
    localparam int EXP_BURST_BUSY  = 0;
`else
    localparam int EXP_BURST_TICKS = 5;
    localparam int EXP_BURST_DONE  = 0;
    localparam int EXP_BURST_OUT   = 1;
    localparam int EXP_BURST_BUSY  = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_max;
    logic [BW-1:0] burst_len;
    logic          out;
    logic          tick;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_divider_ctrl #(
        .COUNT_WIDTH (CW),
        .DEFAULT_MAX (DMAX),
        .BURST_WIDTH (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_max   (cfg_max),
        .burst_len (burst_len),
        .out       (out),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [CW-1:0] v);
        cfg_max   = v;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int exp_out;
        int exp_tick;
        int exp_rdy;
        int ticks;
        int dones;
        int waited;

        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_max   = '0;
        burst_len = '0;
        step();
        step();
        check("rst_out", int'(out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        rst = 1'b0;
        step();
        $display("phase reset: checks %0d", checks);

        // cfg_max=3 in IDLE, then run and change rate to 1 mid half-period
        cfg_max   = 24'd3;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("idle_cfg_ready_low", int'(cfg_ready), 0);
        step();
        check("idle_cfg_ready_back", int'(cfg_ready), 1);
        step();
        do_start();
        check("start_busy", int'(busy), 1);
        exp_out = 0;
        for (int off = 0; off <= 22; off++) begin
            exp_tick = (off == 3 || off == 7 || off == 11 || off == 15 ||
                        off == 17 || off == 19 || off == 21) ? 1 : 0;
            if (exp_tick == 1) exp_out = 1 - exp_out;
            exp_rdy = (off >= 13 && off <= 15) ? 0 : 1;
            check($sformatf("run_tick_%0d", off), int'(tick), exp_tick);
            check($sformatf("run_out_%0d", off), int'(out), exp_out);
            check($sformatf("run_ready_%0d", off), int'(cfg_ready), exp_rdy);
            cfg_max   = 24'd1;
            cfg_valid = (off == 12);
            stop      = (off == 22);
            step();
        end
        cfg_valid = 1'b0;
        stop      = 1'b0;
        check("stop_wrap_out", int'(out), 0);
        check("stop_wrap_tick", int'(tick), 1);
        check("stop_wrap_busy", int'(busy), 0);
        check("stop_wrap_done", int'(done), 1);
        step();
        check("stop_wrap_done_once", int'(done), 0);
        $display("phase run/cfg: checks %0d", checks);

        // max=4, stop while out=1 at count 1
        load_cfg(24'd4);
        do_start();
        for (int off = 0; off < 6; off++) step();
        check("drain_pre_out", int'(out), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("drain_d1_out", int'(out), 1);
        check("drain_d1_busy", int'(busy), 1);
        step();
        check("drain_d2_out", int'(out), 1);
        check("drain_d2_done", int'(done), 0);
        step();
        check("drain_end_out", int'(out), 0);
        check("drain_end_busy", int'(busy), 0);
        check("drain_end_done", int'(done), 1);
        check("drain_end_tick", int'(tick), 1);
        step();
        check("drain_done_once", int'(done), 0);
        $display("phase drain: checks %0d", checks);

        // start and stop together, then stop while out=0
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("both_busy", int'(busy), 0);
        check("both_done", int'(done), 0);
        step();
        check("both_busy_later", int'(busy), 0);
        do_start();
        check("low_stop_pre_busy", int'(busy), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("low_stop_busy", int'(busy), 0);
        check("low_stop_done", int'(done), 1);
        check("low_stop_out", int'(out), 0);
        step();
        $display("phase start/stop: checks %0d", checks);

        // cfg_max=0 toggles every cycle
        load_cfg(24'd0);
        do_start();
        check("max0_tick0", int'(tick), 1);
        check("max0_out0", int'(out), 1);
        step();
        check("max0_tick1", int'(tick), 1);
        check("max0_out1", int'(out), 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("max0_stop_busy", int'(busy), 0);
        check("max0_stop_out", int'(out), 0);
        step();
        $display("phase max0: checks %0d", checks);

        // burst: max=2, burst_len=4
        load_cfg(24'd2);
        burst_len = 8'd4;
        do_start();
        ticks = 0;
        dones = 0;
        for (int off = 0; off <= 15; off++) begin
            if (tick) ticks++;
            if (done) dones++;
            step();
        end
        burst_len = '0;
        check("burst_ticks", ticks, EXP_BURST_TICKS);
        check("burst_dones", dones, EXP_BURST_DONE);
        check("burst_out", int'(out), EXP_BURST_OUT);
        check("burst_busy", int'(busy), EXP_BURST_BUSY);
        stop   = 1'b1;
        waited = 0;
        while (busy && waited < 10) begin
            step();
            waited++;
        end
        stop = 1'b0;
        check("burst_stop_idle", int'(busy), 0);
        check("burst_stop_out", int'(out), 0);
        step();
        $display("phase burst: checks %0d", checks);

        // reset mid-run with a pending config
        load_cfg(24'd2);
        do_start();
        step();
        step();
        check("rstrun_out_high", int'(out), 1);
        cfg_max   = 24'd9;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("rstrun_pending", int'(cfg_ready), 0);
        rst = 1'b1;
        #1;
        check("rstrun_out", int'(out), 0);
        check("rstrun_busy", int'(busy), 0);
        check("rstrun_tick", int'(tick), 0);
        check("rstrun_done", int'(done), 0);
        check("rstrun_ready", int'(cfg_ready), 1);
        step();
        rst = 1'b0;
        step();
        step();
        do_start();
        for (int off = 0; off <= 7; off++) begin
            check($sformatf("dflt_tick_%0d", off), int'(tick), (off == 6) ? 1 : 0);
            step();
        end
        stop = 1'b1;
        waited = 0;
        while (busy && waited < 20) begin
            step();
            waited++;
        end
        stop = 1'b0;
        check("dflt_stop_idle", int'(busy), 0);
        $display("phase reset-mid-run: checks %0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
